// File: rtl/ledger_pkg.sv
// Shared types for the balance ledger: FSM state encodings, status codes and request kinds.
package ledger_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  typedef enum logic [2:0] {
    ST_OK,
    ST_FUNDS,
    ST_LIMIT,
    ST_OVF,
    ST_CONFLICT
  } status_e;

  typedef enum logic {
    REQ_WD,
    REQ_DEP
  } req_e;

endpackage

// File: rtl/txn_checker.sv
// Combinational accept/reject decision for one withdraw or deposit, plus the
// register values that an accepted transaction would commit.
module txn_checker
  import ledger_pkg::*;
#(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned STEP        = 20,
  parameter int unsigned MAX_BAL     = 60000,
  parameter int unsigned DAILY_LIMIT = 400
) (
  input  req_e             req,
  input  logic [AMT_W-1:0] balance,
  input  logic [AMT_W-1:0] day_total,
  output status_e          status,
  output logic [AMT_W-1:0] balance_next,
  output logic [AMT_W-1:0] day_total_next
);

  // Comparisons use one extra bit so balance + STEP can never wrap.
  localparam logic [AMT_W:0]   StepX  = (AMT_W+1)'(STEP);
  localparam logic [AMT_W:0]   MaxX   = (AMT_W+1)'(MAX_BAL);
  localparam logic [AMT_W:0]   LimitX = (AMT_W+1)'(DAILY_LIMIT);
  localparam logic [AMT_W-1:0] StepA  = AMT_W'(STEP);

  logic [AMT_W:0]   bal_x;
  logic [AMT_W:0]   bal_up;
  logic [AMT_W:0]   day_up;
  logic [AMT_W-1:0] bal_dn;

  assign bal_x  = {1'b0, balance};
  assign bal_up = bal_x + StepX;
  assign day_up = {1'b0, day_total} + StepX;
  assign bal_dn = balance - StepA;

  always_comb begin
    status         = ST_OK;
    balance_next   = balance;
    day_total_next = day_total;
    if (req == REQ_WD) begin
      // First failing check wins: funds before daily limit.
      if (bal_x < StepX) begin
        status = ST_FUNDS;
      end else if (day_up > LimitX) begin
        status = ST_LIMIT;
      end else begin
        balance_next   = bal_dn;
        day_total_next = day_up[AMT_W-1:0];
      end
    end else begin
      if (bal_up > MaxX) begin
        status = ST_OVF;
      end else begin
        balance_next = bal_up[AMT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/balance_ledger.sv
// Account ledger: sequences withdraw/deposit pulses through IDLE -> APPLY -> ACK,
// holds balance and daily withdrawn total, and emits one-cycle status pulses.
module balance_ledger
  import ledger_pkg::*;
#(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned STEP        = 20,
  parameter int unsigned MAX_BAL     = 60000,
  parameter int unsigned DAILY_LIMIT = 400,
  parameter int unsigned INIT_BAL    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_down,
  input  logic             count_up,
  input  logic             day_clear,
  output logic [AMT_W-1:0] balance,
  output logic [AMT_W-1:0] day_total,
  output logic             busy,
  output logic             txn_ok,
  output logic             err_funds,
  output logic             err_limit,
  output logic             err_ovf,
  output logic             err_conflict,
  output logic             dropped
);

  logic [1:0]       state_q, state_d;
  req_e             req_q, req_d;
  status_e          status_q, status_d;
  logic [AMT_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] day_q, day_d;
  logic             dropped_q, dropped_d;

  status_e          chk_status;
  logic [AMT_W-1:0] chk_bal;
  logic [AMT_W-1:0] chk_day;

  txn_checker #(
    .AMT_W      (AMT_W),
    .STEP       (STEP),
    .MAX_BAL    (MAX_BAL),
    .DAILY_LIMIT(DAILY_LIMIT)
  ) u_txn_checker (
    .req           (req_q),
    .balance       (bal_q),
    .day_total     (day_q),
    .status        (chk_status),
    .balance_next  (chk_bal),
    .day_total_next(chk_day)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    status_d  = status_q;
    bal_d     = bal_q;
    day_d     = day_q;
    dropped_d = dropped_q;

    case (state_q)
      IDLE: begin
        if (count_up && count_down) begin
          status_d = ST_CONFLICT;
          state_d  = ACK;
        end else if (count_up || count_down) begin
          req_d   = count_up ? REQ_DEP : REQ_WD;
          state_d = APPLY;
        end
      end
      APPLY: begin
        status_d = chk_status;
        if (chk_status == ST_OK) begin
          bal_d = chk_bal;
          day_d = chk_day;
        end
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && (count_up || count_down)) begin
      dropped_d = 1'b1;
    end

    // Clear overrides a coinciding withdraw commit; the balance still moves.
    if (day_clear) begin
      day_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= REQ_WD;
      status_q  <= ST_OK;
      bal_q     <= AMT_W'(INIT_BAL);
      day_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      status_q  <= status_d;
      bal_q     <= bal_d;
      day_q     <= day_d;
      dropped_q <= dropped_d;
    end
  end

  logic in_ack;
  assign in_ack = (state_q == ACK);

  assign balance      = bal_q;
  assign day_total    = day_q;
  assign busy         = (state_q != IDLE);
  assign dropped      = dropped_q;
  assign txn_ok       = in_ack && (status_q == ST_OK);
  assign err_funds    = in_ack && (status_q == ST_FUNDS);
  assign err_limit    = in_ack && (status_q == ST_LIMIT);
  assign err_ovf      = in_ack && (status_q == ST_OVF);
  assign err_conflict = in_ack && (status_q == ST_CONFLICT);

endmodule
